// File: rtl/bist_pkg.sv
// Shared constants for the ALU BIST stimulus generator: FSM encodings,
// LFSR geometry and the bit slices that feed the CUT operands and opcode.
package bist_pkg;

    localparam int LFSR_W = 16;

    // Taps at bits 15, 13, 12 and 10 give a maximal-length sequence (period 65535).
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    localparam int PAT_A_LSB  = 0;
    localparam int PAT_A_MSB  = 7;
    localparam int PAT_B_LSB  = 8;
    localparam int PAT_B_MSB  = 15;
    localparam int PAT_OP_LSB = 11;
    localparam int PAT_OP_MSB = 13;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CLEAR   = 3'd1;
    localparam logic [2:0] ST_RUN     = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/bist_lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous load; load has priority over advance.
module bist_lfsr16
    import bist_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    input  logic              advance,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] lfsr_d;
    logic [LFSR_W-1:0] lfsr_q;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = load_val;
        end else if (advance) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/bist_pattern_gen.sv
// Sequences one BIST run: clear the signature analyzer, apply NUM_PATTERNS
// pseudo-random vectors to the ALU under test, strobe the signature, report done.
module bist_pattern_gen
    import bist_pkg::*;
#(
    parameter int                NUM_PATTERNS = 255,
    parameter logic [LFSR_W-1:0] SEED         = 16'hACE1,
    parameter int                CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [LFSR_W-1:0] seed_in,
    output logic [7:0]        pat_a,
    output logic [7:0]        pat_b,
    output logic [2:0]        pat_op,
    output logic              pat_valid,
    output logic              sa_clear,
    output logic              sig_capture,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  pattern_count
);

    if (NUM_PATTERNS < 1 || longint'(NUM_PATTERNS) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_params
        $error("bist_pattern_gen: NUM_PATTERNS must lie in 1..2^CNT_W-1");
    end

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(NUM_PATTERNS);

    logic [2:0]        state_d;
    logic [2:0]        state_q;
    logic [CNT_W-1:0]  count_d;
    logic [CNT_W-1:0]  count_q;
    logic [LFSR_W-1:0] last_d;
    logic [LFSR_W-1:0] last_q;
    logic              lfsr_load;
    logic              lfsr_advance;
    logic [LFSR_W-1:0] lfsr_seed;
    logic [LFSR_W-1:0] lfsr_val;
    logic [LFSR_W-1:0] vec;

    // An all-zero seed would lock the LFSR, so fall back to the built-in seed.
    assign lfsr_seed = (seed_in == '0) ? SEED : seed_in;

    bist_lfsr16 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .load     (lfsr_load),
        .load_val (lfsr_seed),
        .advance  (lfsr_advance),
        .q        (lfsr_val)
    );

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        last_d       = last_q;
        lfsr_load    = 1'b0;
        lfsr_advance = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    state_d   = ST_CLEAR;
                    count_d   = '0;
                    lfsr_load = 1'b1;
                end
            end
            ST_CLEAR: begin
                count_d = '0;
                state_d = abort ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                // The vector on the pins this cycle counts even if abort arrives with it.
                count_d      = count_q + CNT_W'(1);
                last_d       = lfsr_val;
                lfsr_advance = 1'b1;
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (count_d == LAST_COUNT) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                state_d = abort ? ST_IDLE : ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        vec = '0;
        if (state_q == ST_RUN) begin
            vec = lfsr_val;
        end else if (state_q == ST_CAPTURE || state_q == ST_DONE) begin
            vec = last_q;
        end
    end

    assign pat_a         = vec[PAT_A_MSB:PAT_A_LSB];
    assign pat_b         = vec[PAT_B_MSB:PAT_B_LSB];
    assign pat_op        = vec[PAT_OP_MSB:PAT_OP_LSB];
    assign pat_valid     = (state_q == ST_RUN);
    assign sa_clear      = (state_q == ST_CLEAR);
    assign sig_capture   = (state_q == ST_CAPTURE);
    assign busy          = (state_q == ST_CLEAR) || (state_q == ST_RUN) || (state_q == ST_CAPTURE);
    assign done          = (state_q == ST_DONE);
    assign pattern_count = count_q;

endmodule
